// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath and memory port.
// The controller side uses master; the datapath/testbench side uses slave.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;
    logic       Zero;
    logic       ALUR31;
    logic       ALUCout;
    logic       mem_ready;
    logic       mul_done;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       mem_req;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [2:0] Load;
    logic [1:0] Store;
    logic       Jalr;
    logic       mul_start;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, funct7b0, Zero, ALUR31, ALUCout, mem_ready, mul_done,
        output PCWrite, AdrSrc, IRWrite, MemWrite, mem_req, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, Load, Store, Jalr, mul_start, retire, illegal, state
    );

    modport slave (
        output op, funct3, funct7b5, funct7b0, Zero, ALUR31, ALUCout, mem_ready, mul_done,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, mem_req, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, Load, Store, Jalr, mul_start, retire, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I(+M) multicycle control FSM sequencing fetch/decode/execute over one shared memory port.
// Latency (zero wait): branch 3, R/I/LUI/AUIPC/store/JAL 4, load/JALR 5 cycles.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready; MULWAIT holds until mul_done.
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit MUL_EN        = 1'b1,
    parameter bit TRAP_HALT     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
        MEMWB   = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6,  EXECI   = 4'd7,
        ALUWB   = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR    = 4'd11,
        LUI     = 4'd12, AUIPC  = 4'd13, MULWAIT = 4'd14, TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t cur, nxt;
    logic   prev_mul;   // previous cycle was MULWAIT: first-cycle detect and mul result select
    logic   rdy;
    logic   take;
    logic [2:0] imm_sel;

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5, input logic rtype);
        case (f3)
            3'b000:  return (rtype && b5) ? 4'h1 : 4'h0;
            3'b001:  return 4'h7;
            3'b010:  return 4'h5;
            3'b011:  return 4'h6;
            3'b100:  return 4'h4;
            3'b101:  return b5 ? 4'h9 : 4'h8;
            3'b110:  return 4'h3;
            default: return 4'h2;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= FETCH;
            prev_mul <= 1'b0;
        end else begin
            cur      <= nxt;
            prev_mul <= (cur == MULWAIT);
        end
    end

    assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_comb begin
        imm_sel = 3'b000;
        case (bus.op)
            OP_STORE:         imm_sel = 3'b001;
            OP_BR:            imm_sel = 3'b010;
            OP_JAL:           imm_sel = 3'b011;
            OP_LUI, OP_AUIPC: imm_sel = 3'b100;
            default:          imm_sel = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  take = bus.Zero;
            3'b001:  take = !bus.Zero;
            3'b100:  take = bus.ALUR31;
            3'b101:  take = !bus.ALUR31;
            3'b110:  take = !bus.ALUCout;
            3'b111:  take = bus.ALUCout;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        nxt            = cur;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 3'b000;
        bus.ALUControl = 4'h0;
        bus.Load       = 3'b000;
        bus.Store      = 2'b00;
        bus.Jalr       = 1'b0;
        bus.mul_start  = 1'b0;
        bus.retire     = 1'b0;
        bus.illegal    = 1'b0;
        // Outputs are forced quiet while reset is asserted so no write escapes mid-instruction.
        if (!reset) begin
            case (cur)
                FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    if (rdy) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        nxt         = DECODE;
                    end
                end
                DECODE: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b01;
                    bus.ImmSrc  = imm_sel;
                    case (bus.op)
                        OP_LOAD, OP_STORE: nxt = MEMADR;
                        OP_R:     nxt = bus.funct7b0 ? (MUL_EN ? MULWAIT : TRAP) : EXECR;
                        OP_I:     nxt = EXECI;
                        OP_BR:    nxt = (bus.funct3[2:1] == 2'b01) ? TRAP : BRANCH;
                        OP_JAL:   nxt = JAL;
                        OP_JALR:  nxt = JALR;
                        OP_LUI:   nxt = LUI;
                        OP_AUIPC: nxt = AUIPC;
                        default:  nxt = TRAP;
                    endcase
                end
                MEMADR: begin
                    bus.ALUSrcA = 2'b10;
                    bus.ALUSrcB = 2'b01;
                    bus.ImmSrc  = imm_sel;
                    nxt         = bus.op[5] ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    bus.mem_req = 1'b1;
                    bus.AdrSrc  = 1'b1;
                    bus.Load    = bus.funct3;
                    if (rdy) nxt = MEMWB;
                end
                MEMWB: begin
                    bus.ResultSrc = 2'b01;
                    bus.RegWrite  = 1'b1;
                    bus.retire    = 1'b1;
                    nxt           = FETCH;
                end
                MEMWRITE: begin
                    bus.mem_req  = 1'b1;
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                    bus.Store    = bus.funct3[1:0];
                    if (rdy) begin
                        bus.retire = 1'b1;
                        nxt        = FETCH;
                    end
                end
                EXECR: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = alu_dec(bus.funct3, bus.funct7b5, 1'b1);
                    nxt            = ALUWB;
                end
                EXECI: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUSrcB    = 2'b01;
                    bus.ImmSrc     = imm_sel;
                    bus.ALUControl = alu_dec(bus.funct3, bus.funct7b5, 1'b0);
                    nxt            = ALUWB;
                end
                ALUWB: begin
                    bus.ResultSrc = prev_mul ? 2'b11 : 2'b00;
                    bus.RegWrite  = 1'b1;
                    bus.retire    = 1'b1;
                    nxt           = FETCH;
                end
                BRANCH: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = 4'h1;
                    bus.PCWrite    = take;
                    bus.retire     = 1'b1;
                    nxt            = FETCH;
                end
                JAL: begin
                    bus.PCWrite = 1'b1;
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                    bus.Jalr    = (bus.op == OP_JALR);
                    nxt         = ALUWB;
                end
                JALR: begin
                    bus.ALUSrcA = 2'b10;
                    bus.ALUSrcB = 2'b01;
                    bus.ImmSrc  = imm_sel;
                    nxt         = JAL;
                end
                LUI: begin
                    bus.ALUSrcB    = 2'b01;
                    bus.ImmSrc     = imm_sel;
                    bus.ALUControl = 4'hA;
                    nxt            = ALUWB;
                end
                AUIPC: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b01;
                    bus.ImmSrc  = imm_sel;
                    nxt         = ALUWB;
                end
                MULWAIT: begin
                    bus.mul_start = !prev_mul;
                    if (prev_mul && bus.mul_done) nxt = ALUWB;
                end
                TRAP: begin
                    bus.illegal = 1'b1;
                    if (!TRAP_HALT) nxt = FETCH;
                end
                default: nxt = FETCH;
            endcase
        end
    end

    assign bus.state = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction state-path table plus hand sequences for waits, mul, traps and reset.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus0();
    multicycle_controller_if bus1();
    multicycle_controller_if bus2();

    multicycle_controller dut0 (.clk(clk), .reset(reset), .bus(bus0));
    multicycle_controller #(.MUL_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    multicycle_controller #(.MUL_EN(1'b0), .TRAP_HALT(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus1.op = bus0.op;         assign bus2.op = bus0.op;
    assign bus1.funct3 = bus0.funct3; assign bus2.funct3 = bus0.funct3;
    assign bus1.funct7b5 = bus0.funct7b5; assign bus2.funct7b5 = bus0.funct7b5;
    assign bus1.funct7b0 = bus0.funct7b0; assign bus2.funct7b0 = bus0.funct7b0;
    assign bus1.Zero = bus0.Zero;     assign bus2.Zero = bus0.Zero;
    assign bus1.ALUR31 = bus0.ALUR31; assign bus2.ALUR31 = bus0.ALUR31;
    assign bus1.ALUCout = bus0.ALUCout; assign bus2.ALUCout = bus0.ALUCout;
    assign bus1.mem_ready = bus0.mem_ready; assign bus2.mem_ready = bus0.mem_ready;
    assign bus1.mul_done = bus0.mul_done;   assign bus2.mul_done = bus0.mul_done;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       b5, zero, r31, cout;
        int         len;
        logic [19:0] path;
        logic [3:0] alu;
        logic       pcw;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [19:0] p5(input logic [3:0] s0, s1, s2, s3, s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                                input logic b5, z, r, c, input int len, input logic [19:0] path,
                                input logic [3:0] alu, input logic pcw);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.b5 = b5; v.zero = z; v.r31 = r; v.cout = c;
        v.len = len; v.path = path; v.alu = alu; v.pcw = pcw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        bus0.op = v.op; bus0.funct3 = v.f3; bus0.funct7b5 = v.b5; bus0.funct7b0 = 1'b0;
        bus0.Zero = v.zero; bus0.ALUR31 = v.r31; bus0.ALUCout = v.cout;
        bus0.mem_ready = 1'b1; bus0.mul_done = 1'b0;
        for (int c = 0; c < v.len; c++) begin
            #1;
            chk({v.name, "_state"}, 32'(bus0.state), 32'(v.path[c*4 +: 4]));
            if (c == 2) chk({v.name, "_alu"}, 32'(bus0.ALUControl), 32'(v.alu));
            if (c == v.len - 1) begin
                chk({v.name, "_retire"}, 32'(bus0.retire), 32'd1);
                chk({v.name, "_pcwrite"}, 32'(bus0.PCWrite), 32'(v.pcw));
            end
            nxt();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,6,8,0),  4'h0, 1'b0);
        vecs[1]  = mk("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4, p5(0,1,6,8,0),  4'h1, 1'b0);
        vecs[2]  = mk("sra",   7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 4, p5(0,1,6,8,0),  4'h9, 1'b0);
        vecs[3]  = mk("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4, p5(0,1,7,8,0),  4'h0, 1'b0);
        vecs[4]  = mk("srli",  7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,7,8,0),  4'h8, 1'b0);
        vecs[5]  = mk("sltiu", 7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,7,8,0),  4'h6, 1'b0);
        vecs[6]  = mk("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5, p5(0,1,2,3,4),  4'h0, 1'b0);
        vecs[7]  = mk("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,2,5,0),  4'h0, 1'b0);
        vecs[8]  = mk("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3, p5(0,1,9,0,0),  4'h1, 1'b1);
        vecs[9]  = mk("bne_t", 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3, p5(0,1,9,0,0),  4'h1, 1'b1);
        vecs[10] = mk("bltu_n",7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 3, p5(0,1,9,0,0),  4'h1, 1'b0);
        vecs[11] = mk("bge_t", 7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3, p5(0,1,9,0,0),  4'h1, 1'b1);
        vecs[12] = mk("blt_n", 7'b1100011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3, p5(0,1,9,0,0),  4'h1, 1'b0);
        vecs[13] = mk("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,10,8,0), 4'h0, 1'b0);
        vecs[14] = mk("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,12,8,0), 4'hA, 1'b0);
        vecs[15] = mk("auipc", 7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, p5(0,1,13,8,0), 4'h0, 1'b0);
        vecs[16] = mk("jalr",  7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5, p5(0,1,11,10,8), 4'h0, 1'b0);

        bus0.op = 7'b0; bus0.funct3 = 3'b0; bus0.funct7b5 = 1'b0; bus0.funct7b0 = 1'b0;
        bus0.Zero = 1'b0; bus0.ALUR31 = 1'b0; bus0.ALUCout = 1'b0;
        bus0.mem_ready = 1'b1; bus0.mul_done = 1'b0;

        // Reset state with mem_ready high: outputs must stay quiet.
        repeat (2) nxt();
        chk("rst_state", 32'(bus0.state), 32'd0);
        chk("rst_mem_req", 32'(bus0.mem_req), 32'd0);
        chk("rst_irwrite", 32'(bus0.IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(bus0.PCWrite), 32'd0);
        chk("rst_illegal", 32'(bus1.illegal), 32'd0);
        reset = 1'b0;
        #1;
        chk("fetch_mem_req", 32'(bus0.mem_req), 32'd1);
        chk("fetch_irwrite", 32'(bus0.IRWrite), 32'd1);
        chk("fetch_srcb", 32'(bus0.ALUSrcB), 32'd2);
        chk("fetch_result", 32'(bus0.ResultSrc), 32'd2);
        bus0.mem_ready = 1'b0;
        #1;
        chk("fetch_wait_irwrite", 32'(bus0.IRWrite), 32'd0);
        nxt();
        chk("fetch_wait_state", 32'(bus0.state), 32'd0);
        chk("fetch_wait_req", 32'(bus0.mem_req), 32'd1);

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Load with two stalled MEMREAD cycles: 7 cycles total.
        bus0.op = 7'b0000011; bus0.funct3 = 3'b010; bus0.mem_ready = 1'b1;
        #1 chk("lwst_c0", 32'(bus0.state), 32'd0);
        nxt(); chk("lwst_c1", 32'(bus0.state), 32'd1);
        nxt(); chk("lwst_c2", 32'(bus0.state), 32'd2);
        bus0.mem_ready = 1'b0;
        nxt(); chk("lwst_c3", 32'(bus0.state), 32'd3);
        chk("lwst_req", 32'(bus0.mem_req), 32'd1);
        chk("lwst_adrsrc", 32'(bus0.AdrSrc), 32'd1);
        chk("lwst_load", 32'(bus0.Load), 32'd2);
        nxt(); chk("lwst_c4", 32'(bus0.state), 32'd3);
        chk("lwst_req2", 32'(bus0.mem_req), 32'd1);
        nxt(); chk("lwst_c5", 32'(bus0.state), 32'd3);
        bus0.mem_ready = 1'b1;
        nxt(); chk("lwst_c6", 32'(bus0.state), 32'd4);
        chk("lwst_result", 32'(bus0.ResultSrc), 32'd1);
        chk("lwst_regwrite", 32'(bus0.RegWrite), 32'd1);
        chk("lwst_retire", 32'(bus0.retire), 32'd1);
        nxt();

        // mul: mul_done in the first MULWAIT cycle is ignored; MUL_EN=0 copies trap.
        bus0.op = 7'b0110011; bus0.funct3 = 3'b000; bus0.funct7b5 = 1'b0; bus0.funct7b0 = 1'b1;
        chk("mul_c0", 32'(bus0.state), 32'd0);
        nxt(); chk("mul_c1", 32'(bus0.state), 32'd1);
        bus0.mul_done = 1'b1;
        nxt(); chk("mul_wait1", 32'(bus0.state), 32'd14);
        chk("mul_start1", 32'(bus0.mul_start), 32'd1);
        chk("nomul_trap", 32'(bus1.state), 32'd15);
        chk("nomul_illegal", 32'(bus1.illegal), 32'd1);
        chk("nomul_nh_illegal", 32'(bus2.illegal), 32'd1);
        nxt(); chk("mul_wait2", 32'(bus0.state), 32'd14);
        chk("mul_start2", 32'(bus0.mul_start), 32'd0);
        chk("nomul_hold", 32'(bus1.illegal), 32'd1);
        chk("nomul_nh_fetch", 32'(bus2.state), 32'd0);
        chk("nomul_nh_clear", 32'(bus2.illegal), 32'd0);
        bus0.mul_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt(); chk("mul_waitn", 32'(bus0.state), 32'd14);
        end
        bus0.mul_done = 1'b1;
        nxt(); chk("mul_wb", 32'(bus0.state), 32'd8);
        chk("mul_result", 32'(bus0.ResultSrc), 32'd3);
        chk("mul_regwrite", 32'(bus0.RegWrite), 32'd1);
        chk("mul_retire", 32'(bus0.retire), 32'd1);
        bus0.mul_done = 1'b0;
        nxt(); chk("mul_done_fetch", 32'(bus0.state), 32'd0);
        chk("nomul_absorb", 32'(bus1.state), 32'd15);

        // Illegal opcode.
        reset = 1'b1;
        #1 chk("rst_clears_trap", 32'(bus1.illegal), 32'd0);
        nxt(); reset = 1'b0;
        bus0.funct7b0 = 1'b0; bus0.op = 7'b1111111;
        nxt(); nxt();
        chk("ill_state", 32'(bus0.state), 32'd15);
        chk("ill_flag", 32'(bus0.illegal), 32'd1);
        chk("ill_nh_state", 32'(bus2.state), 32'd15);
        nxt();
        chk("ill_hold", 32'(bus0.state), 32'd15);
        chk("ill_nh_fetch", 32'(bus2.state), 32'd0);

        // Branch with funct3 01x traps.
        reset = 1'b1; nxt(); reset = 1'b0;
        bus0.op = 7'b1100011; bus0.funct3 = 3'b010;
        nxt(); nxt();
        chk("br010_trap", 32'(bus0.state), 32'd15);

        // Reset during a stalled store drops MemWrite immediately.
        reset = 1'b1; nxt(); reset = 1'b0;
        bus0.op = 7'b0100011; bus0.funct3 = 3'b010; bus0.mem_ready = 1'b1;
        nxt(); nxt();
        bus0.mem_ready = 1'b0;
        nxt(); chk("sw_state", 32'(bus0.state), 32'd5);
        chk("sw_memwrite", 32'(bus0.MemWrite), 32'd1);
        chk("sw_store", 32'(bus0.Store), 32'd2);
        chk("sw_noretire", 32'(bus0.retire), 32'd0);
        nxt(); chk("sw_hold", 32'(bus0.MemWrite), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("sw_rst_memwrite", 32'(bus0.MemWrite), 32'd0);
        chk("sw_rst_req", 32'(bus0.mem_req), 32'd0);
        chk("sw_rst_state", 32'(bus0.state), 32'd0);
        nxt(); reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
